fb_write_arbiter: RTL and testbench

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

---
 rtl/fb_write_arbiter_pkg.sv | 11 +
 rtl/fb_write_arbiter_wr_fifo.sv | 52 +++++
 rtl/fb_write_arbiter.sv | 107 ++++++++++
 tb/tb_fb_write_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_write_arbiter_pkg.sv
// Shared camera-path definitions: pixel/line/pixel-index widths and requester index.
package fb_write_arbiter_pkg;
  localparam int CAM_DATA_WIDTH = 12;
  localparam int CAM_LINE       = 9;
  localparam int CAM_PIXEL      = 10;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_idx_t;
endpackage

// File: rtl/fb_write_arbiter_wr_fifo.sv
// Synchronous FIFO with full/empty flags; a pop frees the slot for a same-cycle push.
module wr_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra MSB on each pointer separates full (MSBs differ) from empty (equal).
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  // Read/write pointers wrapping modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end
endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin merge of two non-stalling pixel writers onto one frame-buffer write port,
// with a per-requester queue, one grant stage and a registered output port.
module fb_write_arbiter
  import fb_write_arbiter_pkg::*;
#(
  parameter int CAM_DATA_WIDTH = fb_write_arbiter_pkg::CAM_DATA_WIDTH,
  parameter int CAM_LINE       = fb_write_arbiter_pkg::CAM_LINE,
  parameter int CAM_PIXEL      = fb_write_arbiter_pkg::CAM_PIXEL,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      a_we,
  input  logic [CAM_DATA_WIDTH-1:0] a_data_wr,
  input  logic [CAM_LINE-1:0]       a_line,
  input  logic [CAM_PIXEL-1:0]      a_pixel,
  input  logic                      b_we,
  input  logic [CAM_DATA_WIDTH-1:0] b_data_wr,
  input  logic [CAM_LINE-1:0]       b_line,
  input  logic [CAM_PIXEL-1:0]      b_pixel,
  output logic                      o_we,
  output logic [CAM_DATA_WIDTH-1:0] o_data_wr,
  output logic [CAM_LINE-1:0]       o_line,
  output logic [CAM_PIXEL-1:0]      o_pixel,
  output logic                      o_src,
  input  logic                      i_clr_ovf,
  output logic                      o_ovf_a,
  output logic                      o_ovf_b
);
  localparam int ENTRY_W = CAM_DATA_WIDTH + CAM_LINE + CAM_PIXEL;

  logic [ENTRY_W-1:0] a_head, b_head, stg_entry;
  logic               a_full, a_empty, b_full, b_empty;
  logic               pop_a, pop_b, a_drop, b_drop, stg_valid;
  req_idx_t           last_grant, stg_src;

  wr_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk(clk), .rst_n(rst_n), .push(a_we), .wdata({a_data_wr, a_line, a_pixel}),
    .pop(pop_a), .rdata(a_head), .full(a_full), .empty(a_empty)
  );

  wr_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk(clk), .rst_n(rst_n), .push(b_we), .wdata({b_data_wr, b_line, b_pixel}),
    .pop(pop_b), .rdata(b_head), .full(b_full), .empty(b_empty)
  );

  assign a_drop = a_we & a_full & ~pop_a;
  assign b_drop = b_we & b_full & ~pop_b;

  // Round-robin grant: A wins contention only if B was granted last.
  always_comb begin
    pop_a = 1'b0;
    pop_b = 1'b0;
    if (!a_empty && (b_empty || last_grant == REQ_B)) begin
      pop_a = 1'b1;
    end else if (!b_empty) begin
      pop_b = 1'b1;
    end else begin
      pop_a = 1'b0;
      pop_b = 1'b0;
    end
  end

  // Grant stage: captures the popped head and remembers who was served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid  <= 1'b0;
      stg_entry  <= '0;
      stg_src    <= REQ_A;
      last_grant <= REQ_B;
    end else begin
      stg_valid <= pop_a | pop_b;
      if (pop_a) begin
        stg_entry  <= a_head;
        stg_src    <= REQ_A;
        last_grant <= REQ_A;
      end else if (pop_b) begin
        stg_entry  <= b_head;
        stg_src    <= REQ_B;
        last_grant <= REQ_B;
      end
    end
  end

  // Output port holds its fields between writes; overflow set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_we      <= 1'b0;
      o_data_wr <= '0;
      o_line    <= '0;
      o_pixel   <= '0;
      o_src     <= 1'b0;
      o_ovf_a   <= 1'b0;
      o_ovf_b   <= 1'b0;
    end else begin
      o_we <= stg_valid;
      if (stg_valid) begin
        o_data_wr <= stg_entry[ENTRY_W-1 -: CAM_DATA_WIDTH];
        o_line    <= stg_entry[CAM_LINE+CAM_PIXEL-1 -: CAM_LINE];
        o_pixel   <= stg_entry[CAM_PIXEL-1:0];
        o_src     <= stg_src;
      end
      o_ovf_a <= a_drop | (o_ovf_a & ~i_clr_ovf);
      o_ovf_b <= b_drop | (o_ovf_b & ~i_clr_ovf);
    end
  end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scenario tasks drive both requesters through a reference queue model; a negedge monitor
// pops the expected-write scoreboard whenever the arbiter presents a write.
module tb_fb_write_arbiter;
  localparam int DW = 12;
  localparam int LW = 9;
  localparam int PW = 10;
  localparam int DEPTH = 4;

  typedef logic [DW+LW+PW-1:0] ent_t;

  logic clk, rst_n;
  logic a_we, b_we, i_clr_ovf;
  logic [DW-1:0] a_data_wr, b_data_wr, o_data_wr;
  logic [LW-1:0] a_line, b_line, o_line;
  logic [PW-1:0] a_pixel, b_pixel, o_pixel;
  logic o_we, o_src, o_ovf_a, o_ovf_b;

  fb_write_arbiter #(.CAM_DATA_WIDTH(DW), .CAM_LINE(LW), .CAM_PIXEL(PW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_we(a_we), .a_data_wr(a_data_wr), .a_line(a_line), .a_pixel(a_pixel),
    .b_we(b_we), .b_data_wr(b_data_wr), .b_line(b_line), .b_pixel(b_pixel),
    .o_we(o_we), .o_data_wr(o_data_wr), .o_line(o_line), .o_pixel(o_pixel), .o_src(o_src),
    .i_clr_ovf(i_clr_ovf), .o_ovf_a(o_ovf_a), .o_ovf_b(o_ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  ent_t qa[$];
  ent_t qb[$];
  logic [DW+LW+PW:0] exp_q[$];
  logic m_last, m_pend, exp_we_cur, m_ovf_a, m_ovf_b, mon_en;
  logic [DW+LW+PW:0] mon_exp, mon_got;

  function automatic logic pred_pop_a();
    return (qa.size() > 0) && (qb.size() == 0 || m_last == 1'b1);
  endfunction

  task automatic reset_model();
    qa.delete();
    qb.delete();
    exp_q.delete();
    m_last = 1'b1;
    m_pend = 1'b0;
    exp_we_cur = 1'b0;
    m_ovf_a = 1'b0;
    m_ovf_b = 1'b0;
  endtask

  // One clock: drive both requesters, advance the reference model, return at edge+1.
  task automatic cycle(input logic aw, input ent_t ea, input logic bw, input ent_t eb, input logic clr);
    logic pa, pb, drop_a, drop_b;
    ent_t t;
    pa = pred_pop_a();
    pb = !pa && (qb.size() > 0);
    {a_we, a_data_wr, a_line, a_pixel} = {aw, ea};
    {b_we, b_data_wr, b_line, b_pixel} = {bw, eb};
    i_clr_ovf = clr;
    if (pa) begin
      t = qa.pop_front();
      exp_q.push_back({1'b0, t});
      m_last = 1'b0;
    end
    if (pb) begin
      t = qb.pop_front();
      exp_q.push_back({1'b1, t});
      m_last = 1'b1;
    end
    drop_a = aw && (qa.size() >= DEPTH);
    drop_b = bw && (qb.size() >= DEPTH);
    if (aw && !drop_a) qa.push_back(ea);
    if (bw && !drop_b) qb.push_back(eb);
    @(posedge clk);
    exp_we_cur = m_pend;
    m_pend = pa | pb;
    m_ovf_a = drop_a | (m_ovf_a & ~clr);
    m_ovf_b = drop_b | (m_ovf_b & ~clr);
    #1;
    a_we = 1'b0;
    b_we = 1'b0;
    i_clr_ovf = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qa.size() > 0 || qb.size() > 0 || m_pend) && n < 40) begin
      cycle(1'b0, '0, 1'b0, '0, 1'b0);
      n++;
    end
  endtask

  // Scoreboard monitor: write strobe, popped entry and overflow flags every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (o_we !== exp_we_cur) begin
        errors++;
        $display("FAIL mon_we: got %b expected %b at %0t", o_we, exp_we_cur, $time);
      end
      if (exp_we_cur && exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        if (o_we === 1'b1) begin
          mon_got = {o_src, o_data_wr, o_line, o_pixel};
          checks++;
          if (mon_got !== mon_exp) begin
            errors++;
            $display("FAIL mon_entry: got %h expected %h at %0t", mon_got, mon_exp, $time);
          end
        end
      end
      checks++;
      if ({o_ovf_a, o_ovf_b} !== {m_ovf_a, m_ovf_b}) begin
        errors++;
        $display("FAIL mon_ovf: got %b%b expected %b%b at %0t", o_ovf_a, o_ovf_b, m_ovf_a, m_ovf_b, $time);
      end
    end
  end

  task automatic test_reset();
    #1;
    checks++;
    if ({o_we, o_data_wr, o_line, o_pixel, o_src, o_ovf_a, o_ovf_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b d=%h l=%h p=%h s=%b ovf=%b%b expected all 0",
               o_we, o_data_wr, o_line, o_pixel, o_src, o_ovf_a, o_ovf_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_alternate();
    logic exp_src;
    int seen;
    exp_src = 1'b0;
    seen = 0;
    for (int i = 0; i < 17; i++) begin
      if (i < 7) cycle(1'b1, {12'h100 + 12'(i), 9'd1, 10'(i)}, 1'b1, {12'h180 + 12'(i), 9'd2, 10'(i)}, 1'b0);
      else cycle(1'b0, '0, 1'b0, '0, 1'b0);
      if (o_we === 1'b1) begin
        seen++;
        checks++;
        if (o_src !== exp_src) begin
          errors++;
          $display("FAIL alt_src: got %b expected %b (write %0d)", o_src, exp_src, seen);
        end
        exp_src = ~exp_src;
      end
    end
    checks++;
    if (seen !== 14) begin
      errors++;
      $display("FAIL alt_count: got %0d expected 14", seen);
    end
    checks++;
    if ({o_ovf_a, o_ovf_b} !== 2'b00) begin
      errors++;
      $display("FAIL alt_ovf: got %b%b expected 00", o_ovf_a, o_ovf_b);
    end
    drain();
  endtask

  task automatic test_single_push();
    cycle(1'b1, {12'hABC, 9'd5, 10'd7}, 1'b0, '0, 1'b0);
    checks++;
    if (o_we !== 1'b0) begin errors++; $display("FAIL single_lat0: got %b expected 0", o_we); end
    cycle(1'b0, '0, 1'b0, '0, 1'b0);
    checks++;
    if (o_we !== 1'b0) begin errors++; $display("FAIL single_lat1: got %b expected 0", o_we); end
    cycle(1'b0, '0, 1'b0, '0, 1'b0);
    checks++;
    if ({o_we, o_src, o_data_wr, o_line, o_pixel} !== {1'b1, 1'b0, 12'hABC, 9'd5, 10'd7}) begin
      errors++;
      $display("FAIL single_out: got we=%b s=%b d=%h l=%0d p=%0d expected we=1 s=0 d=abc l=5 p=7",
               o_we, o_src, o_data_wr, o_line, o_pixel);
    end
    cycle(1'b0, '0, 1'b0, '0, 1'b0);
    checks++;
    if ({o_we, o_data_wr, o_line, o_pixel} !== {1'b0, 12'hABC, 9'd5, 10'd7}) begin
      errors++;
      $display("FAIL single_hold: got we=%b d=%h l=%0d p=%0d expected we=0 d=abc l=5 p=7",
               o_we, o_data_wr, o_line, o_pixel);
    end
    drain();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, {12'h200 + 12'(i), 9'd3, 10'(i)}, 1'b1, {12'h300 + 12'(i), 9'd4, 10'(i)}, 1'b0);
    end
    checks++;
    if ({o_ovf_a, o_ovf_b} !== 2'b11) begin
      errors++;
      $display("FAIL ovf_set: got %b%b expected 11", o_ovf_a, o_ovf_b);
    end
  endtask

  task automatic test_clear();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      if (qa.size() == DEPTH && !pred_pop_a()) begin
        found = 1'b1;
        cycle(1'b1, {12'h280 + 12'(i), 9'd5, 10'(i)}, 1'b1, {12'h380 + 12'(i), 9'd6, 10'(i)}, 1'b1);
        checks++;
        if (o_ovf_a !== 1'b1) begin errors++; $display("FAIL clr_coincident: got %b expected 1", o_ovf_a); end
      end else begin
        cycle(1'b1, {12'h280 + 12'(i), 9'd5, 10'(i)}, 1'b1, {12'h380 + 12'(i), 9'd6, 10'(i)}, 1'b0);
      end
    end
    checks++;
    if (found !== 1'b1) begin errors++; $display("FAIL clr_setup: got %b expected 1", found); end
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    checks++;
    if ({o_ovf_a, o_ovf_b} !== 2'b00) begin
      errors++;
      $display("FAIL clr_alone: got %b%b expected 00", o_ovf_a, o_ovf_b);
    end
    drain();
  endtask

  task automatic test_full_push_pop();
    logic hit, pa, aw;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      pa = pred_pop_a();
      aw = (qa.size() < DEPTH) || pa;
      hit = (qa.size() == DEPTH) && pa;
      cycle(aw, {12'h600 + 12'(i), 9'd7, 10'(i)}, 1'b1, {12'h700 + 12'(i), 9'd8, 10'(i)}, 1'b0);
      if (hit) begin
        checks++;
        if (o_ovf_a !== 1'b0) begin errors++; $display("FAIL ffpp_ovf: got %b expected 0", o_ovf_a); end
      end
    end
    checks++;
    if (hit !== 1'b1) begin errors++; $display("FAIL ffpp_setup: got %b expected 1", hit); end
    drain();
    checks++;
    if (o_ovf_a !== 1'b0) begin errors++; $display("FAIL ffpp_ovf_end: got %b expected 0", o_ovf_a); end
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, {12'h400 + 12'(i), 9'd9, 10'(i)}, 1'b1, {12'h500 + 12'(i), 9'd10, 10'(i)}, 1'b0);
    end
    #2;
    rst_n = 1'b0;
    reset_model();
    #1;
    checks++;
    if ({o_we, o_data_wr, o_line, o_pixel, o_src, o_ovf_a, o_ovf_b} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got we=%b d=%h l=%h p=%h s=%b expected all 0",
               o_we, o_data_wr, o_line, o_pixel, o_src);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b0, '0, 1'b0);
      checks++;
      if (o_we !== 1'b0) begin errors++; $display("FAIL midrst_idle%0d: got %b expected 0", i, o_we); end
    end
    cycle(1'b0, '0, 1'b1, {12'h5A5, 9'd3, 10'd4}, 1'b0);
    cycle(1'b0, '0, 1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0, '0, 1'b0);
    checks++;
    if ({o_we, o_src, o_data_wr} !== {1'b1, 1'b1, 12'h5A5}) begin
      errors++;
      $display("FAIL midrst_newpush: got we=%b s=%b d=%h expected we=1 s=1 d=5a5", o_we, o_src, o_data_wr);
    end
    drain();
  endtask

  initial begin
    rst_n = 1'b0;
    mon_en = 1'b0;
    {a_we, a_data_wr, a_line, a_pixel} = '0;
    {b_we, b_data_wr, b_line, b_pixel} = '0;
    i_clr_ovf = 1'b0;
    reset_model();
    test_reset();
    test_alternate();
    test_single_push();
    test_overflow();
    test_clear();
    test_full_push_pop();
    test_reset_midop();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
